trace_capture: RTL

Instruction-trace capture unit that sits beside the single-cycle CPU and consumes the per-cycle retire stream (pc, inst, addr) that the CPU top drives out. It arms on command, triggers on a programmed PC, and records a fixed-length window of retired instructions into a small FIFO. A host drains that FIFO through a valid/ready read port. Samples that arrive when the FIFO is full are dropped and counted.

---
 rtl/trace_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/trace_capture.sv
// trace_capture: instruction-trace capture beside the CPU retire stream.
// Arms on command, triggers on a programmed PC, records a fixed-length
// window of retired {pc, inst, addr} samples into a show-ahead FIFO that a
// host drains through a valid/ready port. Samples that find the FIFO full
// are dropped and counted.
module trace_capture #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CAP_LEN    = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic [31:0] addr,
  input  logic        trace_en,
  input  logic        arm,
  input  logic [31:0] trig_pc,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_inst,
  output logic [31:0] rd_addr,
  output logic [1:0]  state,
  output logic [15:0] ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(1'b0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(1'b0);
  localparam logic [15:0]           LAST_SMP = 16'(CAP_LEN - 1);
  localparam bit                    SINGLE   = (CAP_LEN == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [95:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [15:0]           smp_cnt_r;
  logic [15:0]           ovf_cnt_r;
  logic                  full_s;
  logic                  pop_s;
  logic                  sample_s;
  logic                  push_s;
  logic                  drop_s;

  assign rd_valid = (count_r != CNT_ZERO);
  assign rd_pc    = mem_r[rd_ptr_r][95:64];
  assign rd_inst  = mem_r[rd_ptr_r][63:32];
  assign rd_addr  = mem_r[rd_ptr_r][31:0];
  assign state    = state_r;
  assign ovf_cnt  = ovf_cnt_r;

  // Decide whether this cycle's retire slot is a sample and where it goes.
  always_comb begin
    full_s   = (count_r == FULL_CNT);
    pop_s    = rd_valid && rd_ready;
    sample_s = 1'b0;
    case (state_r)
      ARMED:   sample_s = trace_en && (pc == trig_pc);
      CAPTURE: sample_s = trace_en;
      default: sample_s = 1'b0;
    endcase
    // A full FIFO still accepts when the head leaves on the same edge.
    push_s = sample_s && (!full_s || pop_s);
    drop_s = sample_s && full_s && !pop_s;
  end

  // Next capture state; arm restarts the window from any state.
  always_comb begin
    state_next_s = state_r;
    if (arm) begin
      state_next_s = ARMED;
    end else begin
      case (state_r)
        IDLE: state_next_s = IDLE;
        ARMED: begin
          if (sample_s) begin
            state_next_s = SINGLE ? DONE : CAPTURE;
          end else begin
            state_next_s = ARMED;
          end
        end
        CAPTURE: begin
          // smp_cnt_r still holds the pre-edge count here.
          if (sample_s && (smp_cnt_r == LAST_SMP)) begin
            state_next_s = DONE;
          end else begin
            state_next_s = CAPTURE;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Control state, FIFO pointers/occupancy and window counters.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r   <= IDLE;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      smp_cnt_r <= 16'd0;
      ovf_cnt_r <= 16'd0;
    end else if (arm) begin
      state_r   <= state_next_s;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      smp_cnt_r <= 16'd0;
      ovf_cnt_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (sample_s) begin
        smp_cnt_r <= smp_cnt_r + 16'd1;
      end
      if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 16'd1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_in) begin
    if (push_s && !arm && !reset) begin
      mem_r[wr_ptr_r] <= {pc, inst, addr};
    end
  end

endmodule
